cpu_control_sequencer: RTL and testbench
========================================

Name: cpu_control_sequencer

Overview:
- Six-step stepper plus instruction decoder for the 8-bit CPU.
- Drives every load/output enable of the register set: IR, IAR, ACC, FLAGS, TEMP, GPR R0–R3, display and zero registers. Also drives the RAM/MAR strobes and the ALU opcode.
- Steps 1–3 fetch the instruction; steps 4–6 execute the opcode latched in IR. Supports run/stop single-stepping and a sticky HALT.

Parameters:
- HALT_OPCODE, 8'h7F, IR value that stops the stepper until reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears stepper and halt state
- run  input  1  step enable; low = freeze current step, all control outputs 0
- ir  input  8  current instruction from IR_BUS
- flags  input  4  [3]=C, [2]=Gr, [1]=E, [0]=Z from the flags register
- step  output  6  one-hot current step, bit0 = step 1
- halted  output  1  high once HALT executed
- iir, iiar, oiar, iacc, oacc, iflags, itemp, o_1  output  1 each  register enables (o_1 = bus-1 constant onto ALU B side)
- or_en  output  4  GPR output enables, bit n = Rn
- ir_en  output  4  GPR input enables, bit n = Rn
- idisp_reg, ozero_reg  output  1 each  display load / zero-register drive
- imar, oram, iram  output  1 each  MAR load, RAM read-to-bus, RAM write-from-bus
- alu_op  output  3  ALU function: 000 ADD, 001 SHR, 010 SHL, 011 NOT, 100 AND, 101 OR, 110 XOR, 111 CMP
- clf  output  1  clear-flags strobe

Behaviour:
- State consists of a step register (one-hot, 6 bits) and a halted flag. Reset: step = 6'b000001, halted = 0.
- All control outputs are combinational decodes of (step, ir, flags).
- Outputs are forced to 0 in three cases: reset is high, run = 0, or halted = 1.
- alu_op defaults to 000 when not decoded.
- Advance rule: on each clk with run = 1 and halted = 0, step rotates left; step 6 wraps to step 1. run = 0 holds the step.
- Fetch, identical for every opcode:
  - s1: o_1, oiar, imar, iacc (ACC = IAR+1).
  - s2: oram, iir.
  - s3: oacc, iiar.
- Execute, decoded from ir with a = ir[3:2] and b = ir[1:0]:
  - 1ooo aabb ALU:
    - s4: or_en[b], itemp.
    - s5: or_en[a], alu_op = ir[6:4], iacc, iflags.
    - s6: oacc, ir_en[b]. For CMP (111), s6 drives nothing.
  - 0000 aabb LD: s4: or_en[a], imar. s5: oram, ir_en[b].
  - 0001 aabb ST: s4: or_en[a], imar. s5: or_en[b], iram.
  - 0010 00bb DATA:
    - s4: o_1, oiar, imar, iacc.
    - s5: oram, ir_en[b].
    - s6: oacc, iiar.
  - 0011 00bb JMPR: s4: or_en[b], iiar.
  - 0100 0000 JMP: s4: oiar, imar. s5: oram, iiar.
  - 0101 caez Jcond:
    - s4: o_1, oiar, imar, iacc.
    - s5: oacc, iiar.
    - s6: if (ir[3:0] & flags) != 0 then oram, iiar.
  - 0110 0000 CLF: s4: clf.
  - 0111 00bb OUT: s4: or_en[b], idisp_reg.
  - HALT_OPCODE: s4 sets halted at the clock edge; the step holds at s4 thereafter.
  - Any other encoding is a NOP: s4–s6 drive nothing.
- ozero_reg is asserted in any active step where no bus source (or_en, oiar, oacc, oram) is asserted.
- Invariants:
  - At most one bus source is active per step.
  - At most one bit of or_en and at most one bit of ir_en is set.
- Reset mid-instruction returns to s1 immediately; outputs go to 0 while reset is held.
- run deasserted mid-instruction resumes the same step, with no lost or repeated enables.
- halted cleared only by reset.

Test Plan:
- Reset, run=1, ir=8'h00: step sequence 01,02,04,08,10,20,01. s1 = {o_1,oiar,imar,iacc}, s2 = {oram,iir}, s3 = {oacc,iiar}.
- ir=8'h86 (ADD R1,R2): s4 or_en=0100, itemp. s5 or_en=0010, alu_op=000, iacc, iflags. s6 oacc, ir_en=0100. ir=8'hF6 (CMP): s6 all zero, ozero_reg=1.
- ir=8'h58 (JC), flags=4'b1000: s6 oram, iiar. Same with flags=4'b0111: s6 no oram/iiar, ozero_reg=1.
- ir=8'h21 (DATA R1): s4 o_1, oiar, imar, iacc. s5 oram, ir_en=0010. s6 oacc, iiar.
- ir=8'h7F at s4: halted=1 next cycle, step frozen at 08, outputs 0 for 10 cycles. Assert reset: step=01, halted=0.
- run dropped during s2 for 3 cycles: step stays 02, iir=0. After run returns: iir pulses once, then s3. Reset asserted at s5: step=01 asynchronously.

Source files
------------

// File: rtl/cpu_control_sequencer_if.sv
// Control bundle between the sequencer and the 8-bit CPU datapath:
// status inputs (run, ir, flags) and every register/RAM/ALU control line.
interface cpu_control_sequencer_if;
    logic       run;
    logic [7:0] ir;
    logic [3:0] flags;
    logic [5:0] step;
    logic       halted;
    logic       iir, iiar, oiar, iacc, oacc, iflags, itemp, o_1;
    logic [3:0] or_en;
    logic [3:0] ir_en;
    logic       idisp_reg, ozero_reg;
    logic       imar, oram, iram;
    logic [2:0] alu_op;
    logic       clf;

    modport master (
        output run, ir, flags,
        input  step, halted, iir, iiar, oiar, iacc, oacc, iflags, itemp, o_1,
        input  or_en, ir_en, idisp_reg, ozero_reg, imar, oram, iram, alu_op, clf
    );

    modport slave (
        input  run, ir, flags,
        output step, halted, iir, iiar, oiar, iacc, oacc, iflags, itemp, o_1,
        output or_en, ir_en, idisp_reg, ozero_reg, imar, oram, iram, alu_op, clf
    );
endinterface

// File: rtl/cpu_control_sequencer.sv
// Six-step stepper and instruction decoder: steps 1-3 fetch, steps 4-6 execute IR.
// Control outputs are combinational decodes of (step, ir, flags), gated by reset/run/halted.
module cpu_control_sequencer #(
    parameter logic [7:0] HALT_OPCODE = 8'h7F
) (
    input logic                    clk,
    input logic                    reset,
    cpu_control_sequencer_if.slave bus
);
    typedef enum logic [5:0] {
        S1 = 6'b000001,
        S2 = 6'b000010,
        S3 = 6'b000100,
        S4 = 6'b001000,
        S5 = 6'b010000,
        S6 = 6'b100000
    } step_t;

    step_t r_step;
    logic  r_halted;

    logic       w_active, w_is_halt;
    logic [1:0] w_a, w_b;
    logic       w_iir, w_iiar, w_oiar, w_iacc, w_oacc, w_iflags, w_itemp, w_o_1;
    logic [3:0] w_or_en, w_ir_en;
    logic       w_idisp, w_imar, w_oram, w_iram, w_clf;
    logic [2:0] w_alu_op;

    assign w_a       = bus.ir[3:2];
    assign w_b       = bus.ir[1:0];
    assign w_is_halt = (bus.ir == HALT_OPCODE);
    assign w_active  = !reset && bus.run && !r_halted;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_step   <= S1;
            r_halted <= 1'b0;
        end else if (bus.run && !r_halted) begin
            if (r_step == S4 && w_is_halt) begin
                r_halted <= 1'b1;
            end else begin
                unique case (r_step)
                    S1:      r_step <= S2;
                    S2:      r_step <= S3;
                    S3:      r_step <= S4;
                    S4:      r_step <= S5;
                    S5:      r_step <= S6;
                    S6:      r_step <= S1;
                    default: r_step <= S1;
                endcase
            end
        end
    end

    always_comb begin
        w_iir    = 1'b0; w_iiar  = 1'b0; w_oiar   = 1'b0; w_iacc  = 1'b0;
        w_oacc   = 1'b0; w_iflags = 1'b0; w_itemp = 1'b0; w_o_1   = 1'b0;
        w_or_en  = '0;   w_ir_en = '0;   w_idisp  = 1'b0; w_imar  = 1'b0;
        w_oram   = 1'b0; w_iram  = 1'b0; w_clf    = 1'b0; w_alu_op = 3'b000;
        if (w_active) begin
            if (r_step == S1) begin
                w_o_1 = 1'b1; w_oiar = 1'b1; w_imar = 1'b1; w_iacc = 1'b1;
            end else if (r_step == S2) begin
                w_oram = 1'b1; w_iir = 1'b1;
            end else if (r_step == S3) begin
                w_oacc = 1'b1; w_iiar = 1'b1;
            end else if (bus.ir[7]) begin
                // ALU: TEMP <- Rb, ACC <- Ra op TEMP, Rb <- ACC (CMP only updates flags)
                if (r_step == S4) begin
                    w_or_en[w_b] = 1'b1; w_itemp = 1'b1;
                end else if (r_step == S5) begin
                    w_or_en[w_a] = 1'b1; w_alu_op = bus.ir[6:4];
                    w_iacc = 1'b1; w_iflags = 1'b1;
                end else if (bus.ir[6:4] != 3'b111) begin
                    w_oacc = 1'b1; w_ir_en[w_b] = 1'b1;
                end
            end else if (!w_is_halt) begin
                unique case (bus.ir[6:4])
                    3'b000, 3'b001: begin
                        if (r_step == S4) begin
                            w_or_en[w_a] = 1'b1; w_imar = 1'b1;
                        end else if (r_step == S5 && !bus.ir[4]) begin
                            w_oram = 1'b1; w_ir_en[w_b] = 1'b1;
                        end else if (r_step == S5) begin
                            w_or_en[w_b] = 1'b1; w_iram = 1'b1;
                        end
                    end
                    3'b010: if (w_a == 2'b00) begin
                        if (r_step == S4) begin
                            w_o_1 = 1'b1; w_oiar = 1'b1; w_imar = 1'b1; w_iacc = 1'b1;
                        end else if (r_step == S5) begin
                            w_oram = 1'b1; w_ir_en[w_b] = 1'b1;
                        end else begin
                            w_oacc = 1'b1; w_iiar = 1'b1;
                        end
                    end
                    3'b011: if (w_a == 2'b00 && r_step == S4) begin
                        w_or_en[w_b] = 1'b1; w_iiar = 1'b1;
                    end
                    3'b100: if (bus.ir[3:0] == 4'h0) begin
                        if (r_step == S4) begin
                            w_oiar = 1'b1; w_imar = 1'b1;
                        end else if (r_step == S5) begin
                            w_oram = 1'b1; w_iiar = 1'b1;
                        end
                    end
                    3'b101: begin
                        // IAR+1 is parked in IAR at s5 so a not-taken branch skips the target byte
                        if (r_step == S4) begin
                            w_o_1 = 1'b1; w_oiar = 1'b1; w_imar = 1'b1; w_iacc = 1'b1;
                        end else if (r_step == S5) begin
                            w_oacc = 1'b1; w_iiar = 1'b1;
                        end else if ((bus.ir[3:0] & bus.flags) != 4'h0) begin
                            w_oram = 1'b1; w_iiar = 1'b1;
                        end
                    end
                    3'b110: if (bus.ir[3:0] == 4'h0 && r_step == S4) w_clf = 1'b1;
                    3'b111: if (w_a == 2'b00 && r_step == S4) begin
                        w_or_en[w_b] = 1'b1; w_idisp = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.step      = r_step;
    assign bus.halted    = r_halted;
    assign bus.iir       = w_iir;
    assign bus.iiar      = w_iiar;
    assign bus.oiar      = w_oiar;
    assign bus.iacc      = w_iacc;
    assign bus.oacc      = w_oacc;
    assign bus.iflags    = w_iflags;
    assign bus.itemp     = w_itemp;
    assign bus.o_1       = w_o_1;
    assign bus.or_en     = w_or_en;
    assign bus.ir_en     = w_ir_en;
    assign bus.idisp_reg = w_idisp;
    assign bus.ozero_reg = w_active && !((|w_or_en) || w_oiar || w_oacc || w_oram);
    assign bus.imar      = w_imar;
    assign bus.oram      = w_oram;
    assign bus.iram      = w_iram;
    assign bus.alu_op    = w_alu_op;
    assign bus.clf       = w_clf;
endmodule

// File: tb/tb_cpu_control_sequencer.sv
// Directed bench for cpu_control_sequencer: table of per-step expected control words
// plus hand sequences for halt, run-freeze and asynchronous reset.
module tb_cpu_control_sequencer;
    logic clk = 1'b0;
    logic reset;
    cpu_control_sequencer_if bus ();

    cpu_control_sequencer #(.HALT_OPCODE(8'h7F)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Packed control word: step[31:26] halted[25] iir iiar oiar iacc oacc iflags itemp o_1 [24:17]
    // or_en[16:13] ir_en[12:9] idisp[8] ozero[7] imar[6] oram[5] iram[4] alu_op[3:1] clf[0]
    localparam logic [31:0] HLT   = 32'h1 << 25;
    localparam logic [31:0] IIR   = 32'h1 << 24;
    localparam logic [31:0] IIAR  = 32'h1 << 23;
    localparam logic [31:0] OIAR  = 32'h1 << 22;
    localparam logic [31:0] IACC  = 32'h1 << 21;
    localparam logic [31:0] OACC  = 32'h1 << 20;
    localparam logic [31:0] IFLG  = 32'h1 << 19;
    localparam logic [31:0] ITMP  = 32'h1 << 18;
    localparam logic [31:0] O1    = 32'h1 << 17;
    localparam logic [31:0] IDISP = 32'h1 << 8;
    localparam logic [31:0] OZERO = 32'h1 << 7;
    localparam logic [31:0] IMAR  = 32'h1 << 6;
    localparam logic [31:0] ORAM  = 32'h1 << 5;
    localparam logic [31:0] IRAM  = 32'h1 << 4;
    localparam logic [31:0] CLF   = 32'h1;

    function automatic logic [31:0] st(input int unsigned n);
        return 32'h1 << (26 + n - 1);
    endfunction
    function automatic logic [31:0] ore(input int unsigned r);
        return 32'h1 << (13 + r);
    endfunction
    function automatic logic [31:0] ire(input int unsigned r);
        return 32'h1 << (9 + r);
    endfunction
    function automatic logic [31:0] alu(input logic [2:0] op);
        return {28'h0, op, 1'b0};
    endfunction

    typedef struct {
        logic [7:0]  ir;
        logic [3:0]  flags;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[$];
    int   errors = 0;
    int   checks = 0;

    function automatic logic [31:0] snap();
        return {bus.step, bus.halted, bus.iir, bus.iiar, bus.oiar, bus.iacc, bus.oacc,
                bus.iflags, bus.itemp, bus.o_1, bus.or_en, bus.ir_en, bus.idisp_reg,
                bus.ozero_reg, bus.imar, bus.oram, bus.iram, bus.alu_op, bus.clf};
    endfunction

    task automatic chk(input string name, input logic [31:0] exp);
        logic [31:0] got;
        got = snap();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h", name, got, exp);
        end
    endtask

    task automatic add_instr(input logic [7:0] ir, input logic [3:0] fl,
                             input logic [31:0] e4, input logic [31:0] e5, input logic [31:0] e6);
        tbl.push_back('{ir, fl, st(1) | O1 | OIAR | IMAR | IACC});
        tbl.push_back('{ir, fl, st(2) | ORAM | IIR});
        tbl.push_back('{ir, fl, st(3) | OACC | IIAR});
        tbl.push_back('{ir, fl, st(4) | e4});
        tbl.push_back('{ir, fl, st(5) | e5});
        tbl.push_back('{ir, fl, st(6) | e6});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        add_instr(8'h00, 4'h0, ore(0) | IMAR, ORAM | ire(0), OZERO);
        add_instr(8'h86, 4'h0, ore(2) | ITMP, ore(1) | IACC | IFLG | alu(3'b000), OACC | ire(2));
        add_instr(8'hF6, 4'h0, ore(2) | ITMP, ore(1) | IACC | IFLG | alu(3'b111), OZERO);
        add_instr(8'hD9, 4'h0, ore(1) | ITMP, ore(2) | IACC | IFLG | alu(3'b101), OACC | ire(1));
        add_instr(8'h58, 4'b1000, O1 | OIAR | IMAR | IACC, OACC | IIAR, ORAM | IIAR);
        add_instr(8'h58, 4'b0111, O1 | OIAR | IMAR | IACC, OACC | IIAR, OZERO);
        add_instr(8'h21, 4'h0, O1 | OIAR | IMAR | IACC, ORAM | ire(1), OACC | IIAR);
        add_instr(8'h1B, 4'h0, ore(2) | IMAR, ore(3) | IRAM, OZERO);
        add_instr(8'h33, 4'h0, ore(3) | IIAR, OZERO, OZERO);
        add_instr(8'h40, 4'h0, OIAR | IMAR, ORAM | IIAR, OZERO);
        add_instr(8'h60, 4'h0, CLF | OZERO, OZERO, OZERO);
        add_instr(8'h72, 4'h0, ore(2) | IDISP, OZERO, OZERO);
        add_instr(8'h24, 4'h0, OZERO, OZERO, OZERO);

        reset = 1'b1;
        bus.run = 1'b1;
        bus.ir = 8'h00;
        bus.flags = 4'h0;
        tick();
        chk("reset_hold", st(1));
        tick();
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            bus.ir = tbl[i].ir;
            bus.flags = tbl[i].flags;
            @(negedge clk);
            chk($sformatf("vec%0d_ir%02h_s%0d", i, tbl[i].ir, (i % 6) + 1), tbl[i].exp);
            tick();
        end

        // Halt: s4 decodes HALT, then the stepper freezes at s4 with outputs gated off
        bus.ir = 8'h7F;
        bus.flags = 4'h0;
        tick(); tick(); tick();
        @(negedge clk);
        chk("halt_s4", st(4) | OZERO);
        tick();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("halted_c%0d", i), st(4) | HLT);
            tick();
        end
        reset = 1'b1;
        #1;
        chk("halt_reset", st(1));
        tick();
        reset = 1'b0;
        bus.ir = 8'h86;

        // run dropped in s2 for three cycles, then resumes s2 exactly once
        @(negedge clk);
        chk("run_s1", st(1) | O1 | OIAR | IMAR | IACC);
        tick();
        bus.run = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("run_off_c%0d", i), st(2));
            tick();
        end
        bus.run = 1'b1;
        @(negedge clk);
        chk("run_resume_s2", st(2) | ORAM | IIR);
        tick();
        @(negedge clk);
        chk("run_resume_s3", st(3) | OACC | IIAR);
        tick();
        tick();
        @(negedge clk);
        chk("pre_reset_s5", st(5) | ore(1) | IACC | IFLG | alu(3'b000));
        reset = 1'b1;
        #1;
        chk("async_reset_s5", st(1));
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset_s1", st(1) | O1 | OIAR | IMAR | IACC);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
